data_mem_responder: RTL and testbench

- Data-memory responder on the far side of the execute pipeline's memory interface.
- Accepts load/store requests issued in the fetch-read stage and returns load data with fixed 2-cycle latency, so data lands aligned with the second execute stage (x2_mem).
- Serves scalar loads/stores (opcode 0100) and vector loads (opcodes 1100/1101), which burst one lane per cycle for coalescing/dot-product use.

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: scalar loads/stores and vector-load bursts, loads answered at fixed 2-cycle latency.
// Define MEM_OOB_ERR_EN to add rsp_err, which flags out-of-range load lanes and out-of-range stores.
module data_mem_responder #(
    parameter int DEPTH = 1024,
    parameter int VLEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_vec,
    input  logic [15:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_last,
`ifdef MEM_OOB_ERR_EN
    output logic        rsp_err,
`endif
    output logic        busy
);
    // DEPTH must not exceed 32768 (15-bit word index).
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, VEC = 1'b1} state_t;

    logic [15:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [14:0] vec_idx_q, vec_idx_d;
    logic [2:0]  vec_rem_q, vec_rem_d;
    logic        s1_valid_q, s1_valid_d;
    logic [14:0] s1_idx_q, s1_idx_d;
    logic        s1_last_q, s1_last_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
`ifdef MEM_OOB_ERR_EN
    logic        s1_serr_q, s1_serr_d;
    logic        rsp_err_q, rsp_err_d;
`endif

    logic        accept;
    logic        mem_we;
    logic        req_oob;
    logic        s1_oob;
    logic [14:0] req_idx;
    logic [2:0]  len_eff;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = req_addr[0];
    assign req_idx   = req_addr[15:1];
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_oob   = (32'(req_idx) >= DEPTH);
    assign s1_oob    = (32'(s1_idx_q) >= DEPTH);

    always_comb begin
        if (req_len == 3'd0) begin
            len_eff = 3'd1;
        end else if (32'(req_len) > VLEN) begin
            len_eff = 3'(VLEN);
        end else begin
            len_eff = req_len;
        end
    end

    // Issue stage: FSM plus stage-1 register (valid, word index, last-lane flag).
    always_comb begin
        state_d    = state_q;
        vec_idx_d  = vec_idx_q;
        vec_rem_d  = vec_rem_q;
        s1_valid_d = 1'b0;
        s1_idx_d   = s1_idx_q;
        s1_last_d  = 1'b0;
        mem_we     = 1'b0;
`ifdef MEM_OOB_ERR_EN
        s1_serr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        mem_we = !req_oob;
`ifdef MEM_OOB_ERR_EN
                        s1_serr_d = req_oob;
`endif
                    end else begin
                        s1_valid_d = 1'b1;
                        s1_idx_d   = req_idx;
                        if (req_vec && len_eff > 3'd1) begin
                            state_d   = VEC;
                            vec_idx_d = req_idx + 15'd1;
                            vec_rem_d = len_eff - 3'd1;
                        end else begin
                            s1_last_d = 1'b1;
                        end
                    end
                end
            end
            VEC: begin
                s1_valid_d = 1'b1;
                s1_idx_d   = vec_idx_q;
                s1_last_d  = (vec_rem_q == 3'd1);
                vec_idx_d  = vec_idx_q + 15'd1;
                vec_rem_d  = vec_rem_q - 3'd1;
                if (vec_rem_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response stage: array read registered one edge after issue; data holds when idle.
    always_comb begin
        rsp_valid_d = s1_valid_q;
        rsp_last_d  = s1_valid_q && s1_last_q;
        rsp_data_d  = rsp_data_q;
        if (s1_valid_q) begin
            rsp_data_d = s1_oob ? 16'h0000 : mem[s1_idx_q[AW-1:0]];
        end
`ifdef MEM_OOB_ERR_EN
        rsp_err_d = (s1_valid_q && s1_oob) || s1_serr_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx[AW-1:0]] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_idx_q   <= '0;
            vec_rem_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_last_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
`ifdef MEM_OOB_ERR_EN
            s1_serr_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            vec_rem_q   <= vec_rem_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_last_q   <= s1_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
`ifdef MEM_OOB_ERR_EN
            s1_serr_q   <= s1_serr_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == VEC) || s1_valid_q || rsp_valid_q;
`ifdef MEM_OOB_ERR_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (DEPTH=1024, VLEN=4): cycle-exact scenarios plus a scoreboard.
module tb_data_mem_responder;
    localparam int W = 18;  // {err, last, data}
`ifdef MEM_OOB_ERR_EN
    localparam logic OOB_ERR = 1'b1;
`else
    localparam logic OOB_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_vec;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_len;
    logic        rsp_valid, rsp_last, busy;
    logic [15:0] rsp_data;
    logic        err_sig;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .VLEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_vec   (req_vec),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
`ifdef MEM_OOB_ERR_EN
        .rsp_err   (rsp_err_w),
`endif
        .busy      (busy)
    );

`ifdef MEM_OOB_ERR_EN
    logic rsp_err_w;
    assign err_sig = rsp_err_w;
`else
    assign err_sig = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        vec;
        logic [15:0] addr;
        logic [2:0]  len;
        logic [15:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [W-1:0] exp_q[$];
    logic [15:0] model_mem [1024];
    logic [15:0] hold_exp;
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic push_req(input logic we, input logic vec, input logic [15:0] addr,
                            input logic [2:0] len, input logic [15:0] wdata);
        req_t r;
        r.we = we; r.vec = vec; r.addr = addr; r.len = len; r.wdata = wdata;
        req_q.push_back(r);
    endtask

    // Drives one request per cycle when the DUT is ready; updates the model and expected queue.
    task automatic drive_cycle();
        req_t        r;
        int          l;
        logic [14:0] idx, li;
        if (req_ready && req_q.size() > 0) begin
            r = req_q.pop_front();
            req_valid = 1'b1; req_we = r.we; req_vec = r.vec;
            req_addr = r.addr; req_len = r.len; req_wdata = r.wdata;
            idx = r.addr[15:1];
            if (r.we) begin
                if (int'(idx) < 1024) model_mem[idx[9:0]] = r.wdata;
            end else begin
                l = (!r.vec || r.len == 3'd0) ? 1 : (r.len > 3'd4) ? 4 : int'(r.len);
                for (int i = 0; i < l; i++) begin
                    li = idx + 15'(i);
                    if (int'(li) < 1024) exp_q.push_back({1'b0, i == l - 1, model_mem[li[9:0]]});
                    else exp_q.push_back({OOB_ERR, i == l - 1, 16'h0000});
                end
            end
        end else begin
            req_valid = 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_vec   = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_len   = 3'($urandom_range(0, 7));
            req_wdata = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0;
        req_addr = '0; req_len = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_data !== 16'h0) begin n_miss++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
        n_vec++; if (rsp_last !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_last got %b want 0", rsp_last); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (err_sig !== 1'b0) begin n_miss++; $display("FAIL reset_err got %b want 0", err_sig); end
        rst = 1'b0;
        hold_exp = 16'h0000;
    endtask

    task automatic test_store_load();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b0; req_addr = 16'h0010; req_wdata = 16'hBEEF;
        model_mem[10'h008] = 16'hBEEF;
        @(negedge clk);
        req_we = 1'b0; req_wdata = 16'h0000;
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL st_ld_early got valid=%b want 0", rsp_valid); end
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, rsp_last, rsp_data} !== {1'b1, 1'b1, 16'hBEEF}) begin
            n_miss++;
            $display("FAIL st_ld_rsp got v=%b l=%b d=%h want v=1 l=1 d=beef", rsp_valid, rsp_last, rsp_data);
        end
        hold_exp = 16'hBEEF;
    endtask

    task automatic test_vector_burst();
        logic exp_valid;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b0;
            req_addr = 16'h0020 + 16'(2 * i); req_wdata = 16'(i + 1);
            model_mem[10'h010 + 10'(i)] = 16'(i + 1);
        end
        @(negedge clk);
        req_we = 1'b0; req_vec = 1'b1; req_addr = 16'h0020; req_len = 3'd4;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_valid = (c >= 2 && c <= 5);
            n_vec++;
            if (req_ready !== (c >= 4)) begin
                n_miss++; $display("FAIL vec_ready c=%0d got %b want %b", c, req_ready, c >= 4);
            end
            n_vec++;
            if (rsp_valid !== exp_valid) begin
                n_miss++; $display("FAIL vec_valid c=%0d got %b want %b", c, rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                n_vec++;
                if ({rsp_last, rsp_data} !== {c == 5, 16'(c - 1)}) begin
                    n_miss++;
                    $display("FAIL vec_lane c=%0d got l=%b d=%h want l=%b d=%h", c, rsp_last, rsp_data, c == 5, 16'(c - 1));
                end
            end
            if (c == 1 || c == 6) begin
                n_vec++;
                if (busy !== (c == 1)) begin n_miss++; $display("FAIL vec_busy c=%0d got %b want %b", c, busy, c == 1); end
            end
            // Changed request fields while not ready must be ignored.
            if (c == 1) begin req_vec = 1'b0; req_addr = 16'h0000; req_len = 3'd1; end
            if (c == 3) req_valid = 1'b0;
        end
        hold_exp = 16'h0004;
    endtask

    task automatic test_boundaries();
        logic [W-1:0] e;
        push_req(1'b1, 1'b0, 16'h0000, 3'd0, 16'h1234);
        push_req(1'b0, 1'b1, 16'h0020, 3'd7, 16'h0000);
        push_req(1'b0, 1'b1, 16'h0024, 3'd0, 16'h0000);
        push_req(1'b0, 1'b1, 16'hFFFE, 3'd2, 16'h0000);
        push_req(1'b0, 1'b0, 16'h0800, 3'd0, 16'h0000);
        push_req(1'b1, 1'b1, 16'h0026, 3'd4, 16'h0044);
        push_req(1'b0, 1'b0, 16'h0026, 3'd3, 16'h0000);
        for (int c = 0; c < 200 && (req_q.size() > 0 || exp_q.size() > 0 || busy || req_valid); c++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL bnd_extra got d=%h want no response", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    hold_exp = e[15:0];
                    if ({err_sig, rsp_last, rsp_data} !== e) begin
                        n_miss++; $display("FAIL bnd_rsp got %h want %h", {err_sig, rsp_last, rsp_data}, e);
                    end
                end
            end else if (rsp_data !== hold_exp) begin
                n_miss++; $display("FAIL bnd_hold got %h want %h", rsp_data, hold_exp);
            end
            drive_cycle();
        end
        n_vec++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            n_miss++; $display("FAIL bnd_timeout got %0d pending want 0", exp_q.size() + req_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        for (int i = 0; i < 8; i++) push_req(1'b1, 1'b0, 16'h0100 + 16'(2 * i), 3'd0, 16'($urandom));
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0)
                push_req(1'b1, 1'b0, 16'h0100 + 16'(2 * $urandom_range(0, 7)), 3'd0, 16'($urandom));
            else
                push_req(1'b0, 1'($urandom_range(0, 1)), 16'h0100 + 16'(2 * $urandom_range(0, 3)),
                         3'($urandom_range(0, 7)), 16'h0000);
        end
        for (int c = 0; c < 1000 && (req_q.size() > 0 || exp_q.size() > 0 || busy || req_valid); c++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL b2b_extra got d=%h want no response", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    hold_exp = e[15:0];
                    if ({err_sig, rsp_last, rsp_data} !== e) begin
                        n_miss++; $display("FAIL b2b_rsp got %h want %h", {err_sig, rsp_last, rsp_data}, e);
                    end
                end
            end else if (rsp_data !== hold_exp) begin
                n_miss++; $display("FAIL b2b_hold got %h want %h", rsp_data, hold_exp);
            end
            drive_cycle();
        end
        n_vec++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            n_miss++; $display("FAIL b2b_timeout got %0d pending want 0", exp_q.size() + req_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic         seen;
        logic [W-1:0] e;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_vec = 1'b1; req_addr = 16'h0020; req_len = 3'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL mid_rst_ready got %b want 1", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL mid_rst_valid got %b want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        hold_exp = 16'h0000;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_miss++; $display("FAIL mid_rst_stale got valid=1 want 0"); end
        push_req(1'b0, 1'b0, 16'h0022, 3'd0, 16'h0000);
        for (int c = 0; c < 50 && (req_q.size() > 0 || exp_q.size() > 0 || busy || req_valid); c++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL post_rst_extra got d=%h want no response", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    hold_exp = e[15:0];
                    if ({err_sig, rsp_last, rsp_data} !== e) begin
                        n_miss++; $display("FAIL post_rst_rsp got %h want %h", {err_sig, rsp_last, rsp_data}, e);
                    end
                end
            end else if (rsp_data !== hold_exp) begin
                n_miss++; $display("FAIL post_rst_hold got %h want %h", rsp_data, hold_exp);
            end
            drive_cycle();
        end
        n_vec++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            n_miss++; $display("FAIL post_rst_timeout got %0d pending want 0", exp_q.size() + req_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_vector_burst();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
